// File: rtl/otp_pkg.sv
// Purpose: shared keypad/authenticator types: scanner states and the 4x4 key-code table.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package otp_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE,
        RELEASE_DEBOUNCE
    } kp_state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Indexed by {row, col}; rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
    localparam logic [3:0] KEY_CODE [16] = '{
        4'h1,     4'h2, 4'h3,     4'hA,
        4'h4,     4'h5, 4'h6,     4'hB,
        4'h7,     4'h8, 4'h9,     4'hC,
        KEY_STAR, 4'h0, KEY_HASH, 4'hD
    };

    // Index of the lowest active-low row; caller guarantees exactly one row is low.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/kp_sync.sv
// Purpose: 4-bit two-flop synchronizer for the asynchronous keypad row inputs.
// Latency: 2 clk cycles.
// Backpressure: none; free-running, resets to all ones (no row pulled low).
module kp_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // Two back-to-back flops; the first may go metastable, the second filters it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: 4x4 keypad scanner with press/release debounce; one code strobe per physical press.
// Latency: press-to-strobe 2 + 1 + DEBOUNCE_CYCLES + 1 cycles, plus up to 4*SCAN_DIV for column rotation.
// Backpressure: none; user_latch is a one-cycle strobe the consumer must take. Build option KEYPAD_DIGIT_ONLY_EN drops codes 0xA-0xF.
module keypad_scanner
    import otp_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 50_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] user_digit,
    output logic       user_latch,
    output logic       key_busy
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DBC_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DBC_MAX   = '1;

    logic [3:0]    row_s;
    kp_state_t     state, state_nxt;
    logic [1:0]    col, col_nxt;
    logic [SW-1:0] scan_cnt, scan_nxt;
    logic [DW-1:0] dbc_cnt, dbc_nxt, dbc_inc;
    logic [3:0]    pat, pat_nxt;
    logic [1:0]    row_q, row_nxt;
    logic [3:0]    code;
    logic [3:0]    col_n_nxt, digit_nxt;
    logic          latch_nxt, busy_nxt;

    kp_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_s)
    );

    // Next state, counters and registered-output values; everything defaults to hold.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        scan_nxt  = scan_cnt;
        dbc_nxt   = dbc_cnt;
        pat_nxt   = pat;
        row_nxt   = row_q;
        latch_nxt = 1'b0;
        digit_nxt = user_digit;
        code      = KEY_CODE[{row_q, col}];
        dbc_inc   = (dbc_cnt == DBC_MAX) ? dbc_cnt : dbc_cnt + 1'b1;

        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_nxt = '0;
                    // Only a single low row is a key; ghosting/multi-press is ignored.
                    if ($countones(~row_s) == 1) begin
                        pat_nxt   = row_s;
                        row_nxt   = low_row(row_s);
                        dbc_nxt   = '0;
                        state_nxt = DEBOUNCE;
                    end else begin
                        col_nxt = col + 2'd1;
                    end
                end else begin
                    scan_nxt = scan_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s != pat) begin
                    state_nxt = SCAN;
                    col_nxt   = col + 2'd1;
                    dbc_nxt   = '0;
                end else if (dbc_cnt >= DBC_LAST) begin
                    state_nxt = EMIT;
                    dbc_nxt   = '0;
`ifdef KEYPAD_DIGIT_ONLY_EN
                    if (code <= 4'h9) begin
                        latch_nxt = 1'b1;
                        digit_nxt = code;
                    end
`else
                    latch_nxt = 1'b1;
                    digit_nxt = code;
`endif
                end else begin
                    dbc_nxt = dbc_inc;
                end
            end
            EMIT: begin
                state_nxt = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (row_s == 4'hF) begin
                    state_nxt = RELEASE_DEBOUNCE;
                    dbc_nxt   = '0;
                end
            end
            RELEASE_DEBOUNCE: begin
                if (row_s != 4'hF) begin
                    dbc_nxt = '0;
                end else if (dbc_cnt >= DBC_LAST) begin
                    state_nxt = SCAN;
                    col_nxt   = col + 2'd1;
                    scan_nxt  = '0;
                    dbc_nxt   = '0;
                end else begin
                    dbc_nxt = dbc_inc;
                end
            end
            default: begin
                state_nxt = SCAN;
            end
        endcase

        col_n_nxt = ~(4'b0001 << col_nxt);
        busy_nxt  = (state_nxt != SCAN);
    end

    // State, counters and outputs; outputs are registered from their next values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SCAN;
            col        <= 2'd0;
            scan_cnt   <= '0;
            dbc_cnt    <= '0;
            pat        <= 4'hF;
            row_q      <= 2'd0;
            col_n      <= 4'b1110;
            user_digit <= 4'h0;
            user_latch <= 1'b0;
            key_busy   <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            scan_cnt   <= scan_nxt;
            dbc_cnt    <= dbc_nxt;
            pat        <= pat_nxt;
            row_q      <= row_nxt;
            col_n      <= col_n_nxt;
            user_digit <= digit_nxt;
            user_latch <= latch_nxt;
            key_busy   <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: self-checking bench for keypad_scanner with a physical keypad-matrix model.
// Latency: checks press-to-strobe window and strobe spacing against the timing rules.
// Backpressure: n/a.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int D  = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  user_digit;
    logic        user_latch;
    logic        key_busy;

    logic [15:0] keys;          // pressed switches, bit r*4+c
    logic [15:0] prev_keys;
    int          n_chk, n_bad;
    int          cyc;
    int          press_t, prev_t, strobe_cnt, quiet_cnt;
    bit          checking, have_prev, held_after, prev_latch;
    logic [3:0]  last_digit;
    logic [3:0]  exp_q[$];
    int          seen_log[$];
    int          exp_log[$];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .row_n      (row_n),
        .col_n      (col_n),
        .user_digit (user_digit),
        .user_latch (user_latch),
        .key_busy   (key_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Keypad matrix: a closed switch pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    function automatic logic [3:0] code_of(input int r, input int c);
        if (c == 3) return 4'(10 + r);
        if (r == 3) return (c == 0) ? 4'hE : (c == 1) ? 4'h0 : 4'hF;
        return 4'(r * 3 + c + 1);
    endfunction

    function automatic bit emits(input logic [3:0] code);
        bit digit_only;
`ifdef KEYPAD_DIGIT_ONLY_EN
        digit_only = 1'b1;
`else
        digit_only = 1'b0;
`endif
        return !digit_only || (code <= 4'h9);
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Per-cycle check of DUT outputs against the behavioural keypad model.
    always @(negedge clk) begin
        if (checking && reset) begin
            if (keys != prev_keys) held_after = 1'b0;
            prev_keys = keys;
            if ($countones(keys) == 1) quiet_cnt = 0;
            else quiet_cnt++;

            chk(col_n inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}, "col_onehot", col_n, 4'b1110);
            if (user_latch) begin
                strobe_cnt++;
                chk(!prev_latch, "latch_consecutive", 1, 0);
                chk(key_busy, "busy_on_strobe", key_busy, 1);
                chk(exp_q.size() != 0, "unexpected_strobe", user_digit, -1);
                if (exp_q.size() != 0) begin
                    last_digit = exp_q.pop_front();
                    chk(user_digit == last_digit, "strobe_digit", user_digit, last_digit);
                    chk((cyc - press_t) >= D + 3 && (cyc - press_t) <= D + 3 + 4*SD + 4,
                        "latency", cyc - press_t, D + 3);
                    if (have_prev)
                        chk((cyc - prev_t) >= 2*D + 2, "strobe_spacing", cyc - prev_t, 2*D + 2);
                end
                seen_log.push_back(int'(user_digit));
                prev_t     = cyc;
                have_prev  = 1'b1;
                held_after = 1'b1;
            end else begin
                chk(user_digit == last_digit, "digit_hold", user_digit, last_digit);
            end
            if (quiet_cnt > D + 6) chk(!key_busy, "busy_idle", key_busy, 0);
            if (held_after && !user_latch) chk(key_busy, "busy_held", key_busy, 1);
            prev_latch = user_latch;
        end
    end

    task automatic press_release(input int r, input int c, input int hold, input int rel);
        int s0;
        s0 = strobe_cnt;
        if (emits(code_of(r, c))) exp_q.push_back(code_of(r, c));
        press_t = cyc;
        keys = 16'(1) << (r*4 + c);
        repeat (hold) step();
        chk(key_busy, "busy_end_of_hold", key_busy, 1);
        keys = '0;
        repeat (4) step();
        chk(key_busy, "busy_release_db", key_busy, 1);
        repeat (rel - 4) step();
        chk(exp_q.size() == 0, "missing_strobe", exp_q.size(), 0);
        chk(strobe_cnt - s0 == (emits(code_of(r, c)) ? 1 : 0), "strobe_count",
            strobe_cnt - s0, emits(code_of(r, c)) ? 1 : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s0, k;
        logic [3:0] col_seen;
        n_chk = 0; n_bad = 0; cyc = 0; strobe_cnt = 0; quiet_cnt = 100;
        checking = 0; have_prev = 0; held_after = 0; prev_latch = 0;
        last_digit = 4'h0; keys = '0; prev_keys = '0; press_t = 0; prev_t = 0;
        reset = 1'b0;
        repeat (3) step();
        chk(col_n == 4'b1110, "reset_col_n", col_n, 4'b1110);
        chk(user_digit == 4'h0, "reset_digit", user_digit, 0);
        chk(user_latch == 1'b0, "reset_latch", user_latch, 0);
        chk(key_busy == 1'b0, "reset_busy", key_busy, 0);
        reset = 1'b1;
        checking = 1;
        repeat (20) step();

        // Clean '5'.
        press_release(1, 1, 60, 40);

        // Bouncing '9': eight 3-cycle phases, then stable.
        s0 = strobe_cnt;
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? (16'(1) << (2*4 + 2)) : 16'h0;
            repeat (3) step();
        end
        chk(strobe_cnt == s0, "bounce_no_strobe", strobe_cnt - s0, 0);
        exp_q.push_back(code_of(2, 2));
        press_t = cyc;
        keys = 16'(1) << (2*4 + 2);
        repeat (60) step();
        keys = '0;
        repeat (40) step();
        chk(strobe_cnt - s0 == 1, "bounce_strobe_count", strobe_cnt - s0, 1);

        // '*' then '0'.
        press_release(3, 0, 60, 40);
        press_release(3, 1, 60, 40);

        // Rows 0 and 2 in column 1: ghost pattern, never a key.
        s0 = strobe_cnt;
        col_seen = '0;
        keys = (16'(1) << (0*4 + 1)) | (16'(1) << (2*4 + 1));
        for (int i = 0; i < 40; i++) begin
            step();
            for (int c = 0; c < 4; c++) if (!col_n[c]) col_seen[c] = 1'b1;
            chk(!key_busy, "multi_busy", key_busy, 0);
        end
        chk(col_seen == 4'hF, "multi_col_rotate", col_seen, 4'hF);
        chk(strobe_cnt == s0, "multi_no_strobe", strobe_cnt - s0, 0);
        keys = '0;
        repeat (20) step();

        // '3' held, reset while waiting for release.
        s0 = strobe_cnt;
        exp_q.push_back(code_of(0, 2));
        press_t = cyc;
        keys = 16'(1) << (0*4 + 2);
        k = 0;
        while (strobe_cnt == s0 && k < 60) begin
            step();
            k++;
        end
        chk(strobe_cnt == s0 + 1, "pre_reset_strobe", strobe_cnt - s0, 1);
        repeat (5) step();
        checking = 0;
        reset = 1'b0;
        #1;
        chk(col_n == 4'b1110, "midreset_col_n", col_n, 4'b1110);
        chk(user_digit == 4'h0, "midreset_digit", user_digit, 0);
        chk(user_latch == 1'b0, "midreset_latch", user_latch, 0);
        chk(key_busy == 1'b0, "midreset_busy", key_busy, 0);
        exp_q.delete();
        last_digit = 4'h0; have_prev = 0; held_after = 0; prev_latch = 0;
        repeat (3) step();
        reset = 1'b1;
        s0 = strobe_cnt;
        exp_q.push_back(code_of(0, 2));
        press_t = cyc;
        checking = 1;
        repeat (60) step();
        keys = '0;
        repeat (40) step();
        chk(strobe_cnt - s0 == 1, "post_reset_strobe", strobe_cnt - s0, 1);
        chk(exp_q.size() == 0, "post_reset_missing", exp_q.size(), 0);

        // 1, 2, 3, 4.
        press_release(0, 0, 60, 40);
        press_release(0, 1, 60, 40);
        press_release(0, 2, 60, 40);
        press_release(1, 0, 60, 40);

`ifdef KEYPAD_DIGIT_ONLY_EN
        exp_log = '{5, 9, 0, 3, 3, 1, 2, 3, 4};
`else
        exp_log = '{5, 9, 14, 0, 3, 3, 1, 2, 3, 4};
`endif
        chk(seen_log.size() == exp_log.size(), "log_length", seen_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < seen_log.size(); i++)
            chk(seen_log[i] == exp_log[i], "log_code", seen_log[i], exp_log[i]);

        checking = 0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
